// File: rtl/minimax_sram_pkg.sv
// Shared types and helpers for the SRAM read-modify-write sequencer.
package minimax_sram_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int MAX_W      = 256;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        MERGE,
        WRITE,
        RESP
    } state_t;

    // Width-generic up to MAX_W; callers pad and truncate to their own width.
    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0]   old_w,
        input logic [MAX_W-1:0]   new_w,
        input logic [MAX_W/8-1:0] strb
    );
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_W / 8; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_w[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/minimax_sram_rmw.sv
// Valid/ready word request sequencer for a single-port full-word SRAM.
// Partial writes become read-modify-write; en pulses never touch.
module minimax_sram_rmw
    import minimax_sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_en,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    state_t              r_state;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_sram_en;
    logic                r_sram_wen;
    logic [ADDR_W-1:0]   r_sram_addr;
    logic [DATA_W-1:0]   r_sram_wdata;
    logic                r_rsp_valid;

    logic                w_hs;
    logic                w_partial;
    logic [DATA_W-1:0]   w_merged;

    assign req_ready = (r_state == IDLE) || (r_state == RESP);
    assign w_hs      = req_valid && req_ready;
    assign w_partial = r_write && (r_wstrb != '1);

    assign w_merged = DATA_W'(byte_merge(MAX_W'(sram_rdata),
                                         MAX_W'(r_wdata),
                                         (MAX_W/8)'(r_wstrb)));

    assign sram_en    = r_sram_en;
    assign sram_wen   = r_sram_wen;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;
    assign rsp_valid  = r_rsp_valid;
    // Read data comes straight from the SRAM, valid in the RESP cycle.
    assign rsp_rdata  = (r_state == RESP && !r_write) ? sram_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_sram_en    <= 1'b0;
            r_sram_wen   <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_rsp_valid  <= 1'b0;
        end else begin
            r_sram_en   <= 1'b0;
            r_sram_wen  <= 1'b0;
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                IDLE, RESP: begin
                    if (w_hs) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_wstrb <= req_wstrb;
                        if (req_write && req_wstrb == '0) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state     <= ACCESS;
                            r_sram_en   <= 1'b1;
                            r_sram_addr <= req_addr;
                            r_sram_wen  <= req_write && (&req_wstrb);
                            if (req_write && (&req_wstrb)) begin
                                r_sram_wdata <= req_wdata;
                            end
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (w_partial) begin
                        r_state <= MERGE;
                    end else begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                MERGE: begin
                    r_wdata      <= w_merged;
                    r_sram_en    <= 1'b1;
                    r_sram_wen   <= 1'b1;
                    r_sram_addr  <= r_addr;
                    r_sram_wdata <= w_merged;
                    r_state      <= WRITE;
                end
                WRITE: begin
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minimax_sram_rmw.sv
// Randomised bench for minimax_sram_rmw with a behavioural memory model.
module tb_minimax_sram_rmw;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        sram_en;
    logic        sram_wen;
    logic [8:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    minimax_sram_rmw dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    function automatic bit [31:0] init_val(input int i);
        return (i * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] got,
                                input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endfunction

    // SRAM wrapper model: physical contents, rdata valid the cycle after en.
    bit [31:0] mem [512];
    bit        mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (sram_en) begin
            if (sram_wen) mem[sram_addr] <= sram_wdata;
            else          sram_rdata     <= mem[sram_addr];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model
    typedef struct {
        int       cyc;
        bit       w;
        bit [8:0] a;
        bit [31:0] d;
        bit [3:0] s;
        bit [7:0] mask;
    } ent_t;

    ent_t      exp_q[$];
    int        hs_log[$];
    bit [31:0] ref_mem [512];
    bit        ref_wr  [512];
    bit        prev_en = 1'b0;
    bit [7:0]  en_mask = '0;
    int        hs_cyc  = 0;

    function automatic bit [31:0] ref_get(input bit [8:0] a);
        return ref_wr[a] ? ref_mem[a] : init_val(int'(a));
    endfunction

    always @(negedge clk) begin
        ent_t e;
        bit   exp_v;
        bit [31:0] old, nw;
        if (reset) begin
            exp_q.delete();
            chk("rst_en", {31'd0, sram_en}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            prev_en = 1'b0;
            en_mask = '0;
        end else begin
            if (sram_en) begin
                chk("en_gap", {31'd0, prev_en}, 32'd0);
                if (cyc - hs_cyc < 8) en_mask[cyc - hs_cyc] = 1'b1;
            end
            prev_en = sram_en;
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc)
                void'(exp_q.pop_front());
            exp_v = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
            if (exp_v) begin
                e = exp_q.pop_front();
                chk("en_pattern", {24'd0, en_mask}, {24'd0, e.mask});
                if (!e.w) begin
                    chk("rsp_rdata_rd", rsp_rdata, ref_get(e.a));
                end else begin
                    chk("rsp_rdata_wr", rsp_rdata, 32'd0);
                    old = ref_get(e.a);
                    nw  = old;
                    for (int b = 0; b < 4; b++)
                        if (e.s[b]) nw[b*8 +: 8] = e.d[b*8 +: 8];
                    ref_mem[e.a] = nw;
                    ref_wr[e.a]  = 1'b1;
                end
            end
            if (req_valid && req_ready) begin
                e.w = req_write;
                e.a = req_addr;
                e.d = req_wdata;
                e.s = req_wstrb;
                if (!req_write) begin
                    e.cyc = cyc + 2; e.mask = 8'h02;
                end else if (req_wstrb == 4'h0) begin
                    e.cyc = cyc + 1; e.mask = 8'h00;
                end else if (req_wstrb == 4'hF) begin
                    e.cyc = cyc + 2; e.mask = 8'h02;
                end else begin
                    e.cyc = cyc + 4; e.mask = 8'h0A;
                end
                exp_q.push_back(e);
                hs_log.push_back(cyc);
                hs_cyc  = cyc;
                en_mask = '0;
            end
        end
    end

    // Drivers: called just after a posedge, return just after the handshake edge.
    task automatic issue(input bit w, input bit [8:0] a,
                         input bit [31:0] d, input bit [3:0] s);
        bit got = 1'b0;
        bit rdy;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                got = 1'b1;
                break;
            end
        end
        chk("hs_timeout", {31'd0, got}, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit [31:0] d);
        bit got = 1'b0;
        d = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                d   = rsp_rdata;
                got = 1'b1;
                break;
            end
        end
        chk("rsp_timeout", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        req_write = 1'($urandom);
        req_addr  = 9'($urandom);
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
    endtask

    initial begin
        bit [31:0] d;
        bit [3:0]  s;
        bit [8:0]  a;
        int        op;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_wen", {31'd0, sram_wen}, 32'd0);
        chk("rst_addr", {23'd0, sram_addr}, 32'd0);
        chk("rst_wdata", sram_wdata, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        issue(1'b0, 9'h000, 32'd0, 4'h0);
        wait_rsp(d);
        chk("rd0_lit", d, 32'h5A5A0000);

        issue(1'b1, 9'h1A5, 32'hDEADBEEF, 4'hF);
        wait_rsp(d);
        chk("fullwr_ack", d, 32'd0);
        issue(1'b0, 9'h1A5, 32'd0, 4'h0);
        wait_rsp(d);
        chk("fullwr_rb", d, 32'hDEADBEEF);

        issue(1'b1, 9'h010, 32'h11223344, 4'hF);
        wait_rsp(d);
        issue(1'b1, 9'h010, 32'hAABBCCDD, 4'h5);
        wait_rsp(d);
        issue(1'b0, 9'h010, 32'd0, 4'h0);
        wait_rsp(d);
        chk("partial_rb", d, 32'h11BB33DD);

        hs_log.delete();
        issue(1'b0, 9'h000, 32'd0, 4'h0);
        issue(1'b0, 9'h001, 32'd0, 4'h0);
        issue(1'b0, 9'h002, 32'd0, 4'h0);
        wait_rsp(d);
        chk("b2b_n", hs_log.size(), 32'd3);
        if (hs_log.size() == 3) begin
            chk("b2b_gap1", hs_log[1] - hs_log[0], 32'd2);
            chk("b2b_gap2", hs_log[2] - hs_log[1], 32'd2);
        end

        issue(1'b1, 9'h020, 32'hCAFEF00D, 4'hF);
        wait_rsp(d);
        issue(1'b1, 9'h020, 32'hFFFFFFFF, 4'h0);
        wait_rsp(d);
        issue(1'b0, 9'h020, 32'd0, 4'h0);
        wait_rsp(d);
        chk("zero_strb_rb", d, 32'hCAFEF00D);

        issue(1'b1, 9'h030, 32'h55555555, 4'hF);
        wait_rsp(d);
        issue(1'b1, 9'h030, 32'hAAAAAAAA, 4'h3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_en", {31'd0, sram_en}, 32'd0);
        chk("midrst_rsp", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        issue(1'b0, 9'h030, 32'd0, 4'h0);
        wait_rsp(d);
        chk("midrst_rb", d, 32'h55555555);

        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 3);
            a  = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 7))
                                             : 9'($urandom);
            case (op)
                0: s = 4'h0;
                1: s = 4'hF;
                2: s = 4'($urandom_range(1, 14));
                default: s = 4'h0;
            endcase
            issue(op != 3, a, $urandom, s);
            if ($urandom_range(0, 2) != 0) begin
                wait_rsp(d);
                repeat ($urandom_range(0, 2)) begin
                    junk();
                    @(posedge clk);
                    #1;
                end
            end
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("drain", exp_q.size(), 32'd0);
        for (int i = 0; i < 32; i++)
            chk("mem_final", mem[i], ref_get(9'(i)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
